// File: rtl/voltmeter_pkg.sv
// Shared definitions for the voltmeter ADC serial link: reader FSM states and default word width.
package voltmeter_pkg;

    localparam int unsigned AdcWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StDone,
        StGap
    } rd_state_e;

endpackage

// File: rtl/sclk_tick_gen.sv
// Half-period timer for the serial clock: one-cycle tick every HALF_DIV enabled cycles.
module sclk_tick_gen #(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HALF_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick_o = en_i && (cnt_q == CntMax);
        cnt_d  = cnt_q;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/read_8bit_serial.sv
// Serial-word reader: drives csn/sclk and shifts in WIDTH bits MSB-first, then strobes data_valid.
// Define READ_CONT_EN for free-running conversions (start ignored, GAP loops back to SETUP).
module read_8bit_serial
    import voltmeter_pkg::*;
#(
    parameter int unsigned WIDTH    = AdcWidth,
    parameter int unsigned HALF_DIV = 2,
    parameter int unsigned GAP_CYC  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sdata_in,
    output logic             csn,
    output logic             sclk,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy
);

    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

`ifdef READ_CONT_EN
    localparam bit ContMode = 1'b1;
`else
    localparam bit ContMode = 1'b0;
`endif

    rd_state_e        state_q;
    logic             csn_q;
    logic             sclk_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] shreg_q;
    logic [BitW-1:0]  bit_cnt_q;
    logic [GapW-1:0]  gap_cnt_q;
    logic             tick;
    logic             tick_en;

    assign tick_en = (state_q == StSetup) || (state_q == StShift);

    sclk_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (tick_en),
        .tick_o (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            csn_q     <= 1'b1;
            sclk_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    csn_q  <= 1'b1;
                    sclk_q <= 1'b0;
                    if (ContMode || start) begin
                        state_q   <= StSetup;
                        csn_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                    end
                end
                StSetup: begin
                    // First rising sclk edge also captures bit WIDTH-1.
                    if (tick) begin
                        state_q <= StShift;
                        sclk_q  <= 1'b1;
                        shreg_q <= {shreg_q[WIDTH-2:0], sdata_in};
                    end
                end
                StShift: begin
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_q    <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (bit_cnt_q == BitW'(WIDTH)) begin
                            state_q <= StDone;
                            csn_q   <= 1'b1;
                        end else begin
                            sclk_q  <= 1'b1;
                            shreg_q <= {shreg_q[WIDTH-2:0], sdata_in};
                        end
                    end
                end
                StDone: begin
                    data_q    <= shreg_q;
                    valid_q   <= 1'b1;
                    state_q   <= StGap;
                    gap_cnt_q <= '0;
                end
                StGap: begin
                    if (gap_cnt_q == GapW'(GAP_CYC - 1)) begin
                        if (ContMode) begin
                            state_q   <= StSetup;
                            csn_q     <= 1'b0;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign csn        = csn_q;
    assign sclk       = sclk_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;

endmodule
